// File: rtl/xp_rr_arb_stage_pkg.sv
// rtl/xp_rr_arb_stage_pkg.sv - shared state encoding for the round-robin packet arbiter stage
package xp_rr_arb_stage_pkg;

    // ARB: free to pick any requester; LOCK: mid-packet, only the owner may advance
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/xp_sel_bit_from_vec.sv
// rtl/xp_sel_bit_from_vec.sv - wrap-around first-set-bit search from a one-hot start position
module xp_sel_bit_from_vec #(
    parameter int VEC_WIDTH = 4
) (
    input  logic [VEC_WIDTH-1:0] in_vec,
    input  logic [VEC_WIDTH-1:0] startx,
    output logic [VEC_WIDTH-1:0] ptr_dec,
    output logic                 found
);

    localparam logic [VEC_WIDTH-1:0] ONE = {{(VEC_WIDTH-1){1'b0}}, 1'b1};

    logic [VEC_WIDTH-1:0] upper_mask;
    logic [VEC_WIDTH-1:0] masked;
    logic [VEC_WIDTH-1:0] search;

    // Prefer set bits at or above startx; fall back to the whole vector to wrap to bit 0
    always_comb begin
        upper_mask = ~(startx - ONE);
        masked     = in_vec & upper_mask;
        search     = (|masked) ? masked : in_vec;
        ptr_dec    = search & (~search + ONE);
        found      = |in_vec;
    end

endmodule

// File: rtl/xp_rr_arb_stage.sv
// rtl/xp_rr_arb_stage.sv - packet-locked round-robin arbiter with a registered output flit
module xp_rr_arb_stage
    import xp_rr_arb_stage_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [NUM_REQ-1:0]        out_src
);

    localparam logic [NUM_REQ-1:0] RR_INIT = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e         state;
    logic [NUM_REQ-1:0] owner;
    logic [NUM_REQ-1:0] rr_ptr;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] winner;
    logic               found;
    logic               load_en;
    logic               accept;
    logic               win_last;
    logic [DATA_W-1:0]  win_data;

    // While a packet is in flight only its owner may compete
    always_comb begin
        load_en = ~out_vld | out_rdy;
        cand    = (state == ST_LOCK) ? (req_vld & owner) : req_vld;
    end

    xp_sel_bit_from_vec #(
        .VEC_WIDTH (NUM_REQ)
    ) u_sel (
        .in_vec  (cand),
        .startx  (rr_ptr),
        .ptr_dec (winner),
        .found   (found)
    );

    // Grant, and AND-OR select of the winner's payload and last flag
    always_comb begin
        accept   = load_en & found;
        req_rdy  = accept ? winner : '0;
        win_last = |(winner & req_last);
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_data = win_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{winner[i]}});
        end
    end

    // Output register: load on accept, drop valid on an empty load slot, hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            out_src  <= '0;
        end else if (load_en) begin
            out_vld <= accept;
            if (accept) begin
                out_data <= win_data;
                out_last <= win_last;
                out_src  <= winner;
            end
        end
    end

    // Packet lock FSM; the pointer only moves past a requester once its packet ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_ARB;
            owner  <= '0;
            rr_ptr <= RR_INIT;
        end else if (accept) begin
            if (win_last) begin
                state  <= ST_ARB;
                owner  <= '0;
                rr_ptr <= {winner[NUM_REQ-2:0], winner[NUM_REQ-1]};
            end else begin
                state  <= ST_LOCK;
                owner  <= winner;
            end
        end
    end

endmodule

// File: tb/tb_xp_rr_arb_stage.sv
// tb/tb_xp_rr_arb_stage.sv - directed self-checking bench for xp_rr_arb_stage
module tb_xp_rr_arb_stage;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_rdy;
    logic            out_vld;
    logic            out_rdy;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [N-1:0]    out_src;

    int tests;
    int failed;

    xp_rr_arb_stage #(
        .NUM_REQ (N),
        .DATA_W  (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_last (req_last),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_last (out_last),
        .out_src  (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dat(input int i);
        return 64'h0123_4567_89AB_CD00 + 64'(i);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [N-1:0] src,
                             input logic [DW-1:0] d, input logic lst);
        check({tag, "_vld"},  64'(out_vld),  64'(vld));
        check({tag, "_src"},  64'(out_src),  64'(src));
        check({tag, "_data"}, out_data,      d);
        check({tag, "_last"}, 64'(out_last), 64'(lst));
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        rst_n    = 1'b0;
        req_vld  = '0;
        req_last = '0;
        out_rdy  = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat(i);

        // reset state
        #3;
        check_out("reset", 1'b0, 4'b0000, '0, 1'b0);
        check("reset_rdy", 64'(req_rdy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // all requesters, single-flit packets: round robin 0,1,2,3,0
        req_vld  = 4'b1111;
        req_last = 4'b1111;
        out_rdy  = 1'b1;
        #1;
        check("rr_rdy0", 64'(req_rdy), 64'b0001);
        tick(); check_out("rr0", 1'b1, 4'b0001, dat(0), 1'b1);
        tick(); check_out("rr1", 1'b1, 4'b0010, dat(1), 1'b1);
        tick(); check_out("rr2", 1'b1, 4'b0100, dat(2), 1'b1);
        tick(); check_out("rr3", 1'b1, 4'b1000, dat(3), 1'b1);
        tick(); check_out("rr4", 1'b1, 4'b0001, dat(0), 1'b1);

        // no requests: valid drops, payload/src hold
        req_vld = 4'b0000;
        tick(); check_out("idle", 1'b0, 4'b0001, dat(0), 1'b1);

        // rr_ptr=0010: 4-flit packet from req 2 while req 0 also waits
        req_vld  = 4'b0101;
        req_last = 4'b0001;
        #1;
        check("pkt_rdy0", 64'(req_rdy), 64'b0100);
        tick(); check_out("pkt_f1", 1'b1, 4'b0100, dat(2), 1'b0);
        check("pkt_lock_rdy", 64'(req_rdy), 64'b0100);
        tick(); check_out("pkt_f2", 1'b1, 4'b0100, dat(2), 1'b0);
        tick(); check_out("pkt_f3", 1'b1, 4'b0100, dat(2), 1'b0);
        req_last = 4'b0101;
        tick(); check_out("pkt_f4", 1'b1, 4'b0100, dat(2), 1'b1);
        // rr_ptr now 1000: search wraps past empty bit 3 to req 0
        check("pkt_after_rdy", 64'(req_rdy), 64'b0001);
        tick(); check_out("pkt_next", 1'b1, 4'b0001, dat(0), 1'b1);

        // backpressure for 5 cycles: outputs hold, no grants
        req_vld  = 4'b1111;
        req_last = 4'b1111;
        out_rdy  = 1'b0;
        #1;
        check("stall_rdy_pre", 64'(req_rdy), 64'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out("stall", 1'b1, 4'b0001, dat(0), 1'b1);
            check("stall_rdy", 64'(req_rdy), 64'h0);
        end
        out_rdy = 1'b1;
        #1;
        check("unstall_rdy", 64'(req_rdy), 64'b0010);
        tick(); check_out("unstall", 1'b1, 4'b0010, dat(1), 1'b1);

        // rr_ptr=0100: lock on req 1 via wrap, then owner drops valid for 2 cycles
        req_vld  = 4'b0010;
        req_last = 4'b0000;
        #1;
        check("lock_rdy", 64'(req_rdy), 64'b0010);
        tick(); check_out("lock_f1", 1'b1, 4'b0010, dat(1), 1'b0);
        req_vld  = 4'b1101;
        req_last = 4'b1101;
        #1;
        check("bubble_rdy", 64'(req_rdy), 64'h0);
        tick(); check_out("bubble1", 1'b0, 4'b0010, dat(1), 1'b0);
        check("bubble1_rdy", 64'(req_rdy), 64'h0);
        tick(); check_out("bubble2", 1'b0, 4'b0010, dat(1), 1'b0);
        req_vld  = 4'b1111;
        req_last = 4'b1101;
        #1;
        check("resume_rdy", 64'(req_rdy), 64'b0010);
        tick(); check_out("lock_f2", 1'b1, 4'b0010, dat(1), 1'b0);

        // asynchronous reset mid-packet with a flit held in the output register
        out_rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 4'b0000, '0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        out_rdy  = 1'b1;
        req_vld  = 4'b1010;
        req_last = 4'b1111;
        #1;
        // lock released and search restarts from bit 0
        check("post_rst_rdy", 64'(req_rdy), 64'b0010);
        tick(); check_out("post_rst", 1'b1, 4'b0010, dat(1), 1'b1);
        req_vld = 4'b1000;
        #1;
        check("r3_rdy", 64'(req_rdy), 64'b1000);
        tick(); check_out("r3", 1'b1, 4'b1000, dat(3), 1'b1);
        // pointer rotated out of MSB back to bit 0
        req_vld = 4'b0011;
        #1;
        check("msb_wrap_rdy", 64'(req_rdy), 64'b0001);
        tick(); check_out("msb_wrap", 1'b1, 4'b0001, dat(0), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
